// File: rtl/bcd_pkg.sv
// Shared constants for the binary<->BCD converter pair: FSM encoding,
// digit width and the double-dabble adjust values.
package bcd_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DIGIT_W = 4;

   localparam logic [3:0] ADJ_VAL    = 4'd3;
   localparam logic [3:0] REV_THRESH = 4'd8;
   localparam logic [3:0] FWD_THRESH = 4'd5;

   function automatic logic digit_bad(input logic [3:0] d);
      return d > 4'd9;
   endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: after a right shift, any digit
// that picked up a weight-8 bit from its upper neighbour is pulled back by 3.
module bcd_digit_sub3
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= REV_THRESH) ? d - ADJ_VAL : d;

endmodule

// File: rtl/reverse_double_dabble.sv
// Sequential BCD-to-binary converter, one result bit per clock (shift right,
// then subtract 3 from every BCD digit >= 8).
module reverse_double_dabble
   import bcd_pkg::*;
#(
   parameter int NDECS    = 3,
   parameter int NBITS    = 10,
   parameter int DEC_BITS = NDECS*4
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DEC_BITS-1:0] decimal,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NBITS-1:0]    binary,
   output logic                overflow,
   output logic                digit_error,
   output logic [1:0]          dbg_state
);

   localparam int TW = DEC_BITS + NBITS;
   localparam int CW = $clog2(NBITS + 1);

   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic [TW-1:0]       temp;
   logic [TW-1:0]       temp_shr;
   logic [TW-1:0]       temp_next;
   logic [DEC_BITS-1:0] bcd_adj;
   logic                dec_err;

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; valid never waits on ready, and payload is held while valid.
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign dbg_state = state;

   assign temp_shr = temp >> 1;

   for (genvar g = 0; g < NDECS; g++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
         .d (temp_shr[NBITS + g*DIGIT_W +: DIGIT_W]),
         .q (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign temp_next = {bcd_adj, temp_shr[NBITS-1:0]};

   always_comb begin
      dec_err = 1'b0;
      for (int g = 0; g < NDECS; g++) begin
         if (digit_bad(decimal[g*DIGIT_W +: DIGIT_W])) dec_err = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         temp        <= '0;
         cnt         <= '0;
         digit_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  temp        <= {decimal, {NBITS{1'b0}}};
                  cnt         <= '0;
                  digit_error <= dec_err;
                  state       <= ST_CONV;
               end
            end
            ST_CONV: begin
               temp <= temp_next;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(NBITS - 1)) state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Whatever is left in the BCD part after NBITS shifts is value >> NBITS.
   assign binary   = (out_valid && !digit_error) ? temp[NBITS-1:0] : '0;
   assign overflow = out_valid && !digit_error && (temp[TW-1:NBITS] != '0);

endmodule

// File: tb/tb_reverse_double_dabble.sv
// Bench for reverse_double_dabble: a 10-bit and an 8-bit instance, checked
// through per-instance expected queues against an arithmetic decimal model.
module tb_reverse_double_dabble;

   logic        clock;
   logic        reset_n;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [11:0] decimal_a;
   logic [9:0]  binary_a;
   logic        overflow_a, digit_error_a;
   logic [1:0]  dbg_a;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [11:0] decimal_b;
   logic [7:0]  binary_b;
   logic        overflow_b, digit_error_b;
   logic [1:0]  dbg_b;

   logic [11:0] exp_a[$];
   logic [11:0] exp_b[$];
   int          acc_a[$];
   int          acc_b[$];
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;
   bit          rnd_ready = 0;
   logic        prev_a = 0;
   logic        prev_b = 0;

   reverse_double_dabble #(.NDECS(3), .NBITS(10)) dut_a (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .decimal(decimal_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .binary(binary_a), .overflow(overflow_a), .digit_error(digit_error_a),
      .dbg_state(dbg_a)
   );

   reverse_double_dabble #(.NDECS(3), .NBITS(8)) dut_b (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .decimal(decimal_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .binary(binary_b), .overflow(overflow_b), .digit_error(digit_error_b),
      .dbg_state(dbg_b)
   );

   // clock / reset block
   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // Reference: decimal value by plain arithmetic, packed as {err, ovf, bin[9:0]}.
   function automatic logic [11:0] model(input logic [11:0] dec, input int nb);
      int   v = 0;
      int   d;
      logic err = 0;
      int   lim = 1 << nb;
      for (int g = 0; g < 3; g++) begin
         d = int'(dec[4*g +: 4]);
         if (d > 9) err = 1;
         v += d * (10 ** g);
      end
      if (err) return {1'b1, 1'b0, 10'd0};
      return {1'b0, (v >= lim), 10'(v % lim)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard push on every accepting edge.
   always @(posedge clock) begin
      cyc = cyc + 1;
      if (reset_n && in_valid_a && in_ready_a) begin
         exp_a.push_back(model(decimal_a, 10));
         acc_a.push_back(cyc);
      end
      if (reset_n && in_valid_b && in_ready_b) begin
         exp_b.push_back(model(decimal_b, 8));
         acc_b.push_back(cyc);
      end
   end

   // Monitors: compare every cycle a result is presented, pop on handshake.
   always @(negedge clock) begin
      if (reset_n && out_valid_a) begin
         if (!prev_a) begin
            if (acc_a.size() == 0) check("a_latency_noacc", 1, 0);
            else check("a_latency", cyc - acc_a.pop_front(), 10);
         end
         if (exp_a.size() == 0) check("a_unexpected_out", 1, 0);
         else begin
            check("a_result", {digit_error_a, overflow_a, binary_a}, exp_a[0]);
            if (out_ready_a) void'(exp_a.pop_front());
         end
      end
      prev_a = reset_n && out_valid_a;
   end

   always @(negedge clock) begin
      if (reset_n && out_valid_b) begin
         if (!prev_b) begin
            if (acc_b.size() == 0) check("b_latency_noacc", 1, 0);
            else check("b_latency", cyc - acc_b.pop_front(), 8);
         end
         if (exp_b.size() == 0) check("b_unexpected_out", 1, 0);
         else begin
            check("b_result", {digit_error_b, overflow_b, 2'b00, binary_b}, exp_b[0]);
            if (out_ready_b) void'(exp_b.pop_front());
         end
      end
      prev_b = reset_n && out_valid_b;
   end

   // Driver: present a value until accepted (called at posedge+1).
   task automatic send(input bit sel, input logic [11:0] dec);
      bit acc = 0;
      if (sel) begin in_valid_b = 1; decimal_b = dec; end
      else begin in_valid_a = 1; decimal_a = dec; end
      for (int i = 0; i < 300 && !acc; i++) begin
         if (rnd_ready) out_ready_a = 1'($urandom_range(0, 1));
         acc = sel ? in_ready_b : in_ready_a;
         @(posedge clock); #1;
      end
      if (!acc) check("send_timeout", 0, 1);
      if (sel) in_valid_b = 0; else in_valid_a = 0;
      decimal_a = (sel) ? decimal_a : 12'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && (exp_a.size() != 0 || exp_b.size() != 0); i++) begin
         @(posedge clock); #1;
      end
      check("drain_a", exp_a.size(), 0);
      check("drain_b", exp_b.size(), 0);
   endtask

   function automatic logic [11:0] rnd_bcd();
      logic [11:0] r;
      for (int g = 0; g < 3; g++)
         r[4*g +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      return r;
   endfunction

   initial begin
      reset_n = 0;
      in_valid_a = 0; decimal_a = 0; out_ready_a = 1;
      in_valid_b = 0; decimal_b = 0; out_ready_b = 1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid_a", out_valid_a, 0);
      check("rst_in_ready_a", in_ready_a, 1);
      check("rst_outputs_a", {digit_error_a, overflow_a, binary_a}, 0);
      check("rst_out_valid_b", out_valid_b, 0);
      check("rst_in_ready_b", in_ready_b, 1);
      check("rst_outputs_b", {digit_error_b, overflow_b, binary_b}, 0);
      reset_n = 1;

      // directed values on both widths
      send(0, 12'h255); drain();
      send(0, 12'h999); drain();
      send(0, 12'h1A3); drain();
      send(0, 12'h000); drain();
      send(1, 12'h999); drain();
      send(1, 12'h255); drain();
      send(1, 12'h256); drain();
      send(1, 12'h1A3); drain();

      // backpressure: held result, new value waiting, no early accept
      out_ready_a = 0;
      send(0, 12'h321);
      for (int i = 0; i < 40 && !out_valid_a; i++) begin @(posedge clock); #1; end
      check("bp_valid", out_valid_a, 1);
      in_valid_a = 1; decimal_a = 12'h678;
      repeat (5) begin
         @(posedge clock); #1;
         check("bp_in_ready", in_ready_a, 0);
      end
      out_ready_a = 1;
      @(posedge clock); #1;
      check("bp_ready_after_hs", in_ready_a, 1);
      @(posedge clock); #1;
      in_valid_a = 0;
      drain();

      // reset during the 4th conversion cycle
      send(0, 12'h456);
      repeat (3) @(posedge clock);
      #2;
      check("abort_in_ready_pre", in_ready_a, 0);
      reset_n = 0;
      #1;
      check("abort_out_valid", out_valid_a, 0);
      check("abort_binary", binary_a, 0);
      check("abort_in_ready", in_ready_a, 1);
      exp_a.delete();
      acc_a.delete();
      @(posedge clock); #1;
      reset_n = 1;
      send(0, 12'h000); drain();

      // randomized traffic with random backpressure
      rnd_ready = 1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) begin
            out_ready_a = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
         end
         send(0, rnd_bcd());
      end
      rnd_ready = 0;
      out_ready_a = 1;
      for (int i = 0; i < 20; i++) send(1, rnd_bcd());
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
